// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with FIFO.
// Ports:
//   clk, rst (sync, active-high)
//   rx: async serial line, idle high
//   rd_en: pop the FIFO head
//   data/valid/count: first-word-fall-through FIFO head, not-empty flag, occupancy
//   frame_err/parity_err/overrun: one-cycle error pulses
module uart_rx_cfg #(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int CPB  = CLOCK_HZ / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic pbad, pbad_n, sbad, sbad_n, push, push_n, fe_n, pe_n, stop_bad;
  logic bit_end, half_end;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, pop, wr;
  assign bit_end  = cnt == CW'(CPB - 1);
  assign half_end = cnt == CW'(HALF - 1);
  assign stop_bad = sbad | ~rxs;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    sh_n    = sh;
    pbad_n  = pbad;
    sbad_n  = sbad;
    push_n  = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        pbad_n = 1'b0;
        sbad_n = 1'b0;
        state_n = rxs ? S_IDLE : S_START;
      end
      S_START: if (half_end) begin
        cnt_n   = '0;
        state_n = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (bit_end) begin
        cnt_n = '0;
        sh_n  = {rxs, sh[DATA_BITS-1:1]};
        idx_n = idx == 4'(DATA_BITS - 1) ? 4'd0 : idx + 4'd1;
        state_n = idx != 4'(DATA_BITS - 1) ? S_DATA : PARITY != 0 ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) begin
        cnt_n   = '0;
        pbad_n  = (^sh ^ rxs) != (PARITY == 1);
        state_n = S_STOP;
      end
      S_STOP: if (bit_end) begin
        cnt_n  = '0;
        idx_n  = idx + 4'd1;
        sbad_n = stop_bad;
        if (idx == 4'(STOP_BITS - 1)) begin
          // Final stop sample: leave for IDLE at once so a following start edge is caught.
          fe_n    = stop_bad;
          pe_n    = pbad;
          push_n  = ~stop_bad & ~pbad;
          state_n = stop_bad ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: state_n = rxs ? S_IDLE : S_BREAK;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b1;
      rxs        <= 1'b1;
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      pbad       <= 1'b0;
      sbad       <= 1'b0;
      push       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      s1         <= rx;
      rxs        <= s1;
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      sh         <= sh_n;
      pbad       <= pbad_n;
      sbad       <= sbad_n;
      push       <= push_n;
      frame_err  <= fe_n;
      parity_err <= pe_n;
    end
  end
  // sh is stable in IDLE/START, so it is still the received byte when push fires.
  assign full  = count == (AW+1)'(FIFO_DEPTH);
  assign pop   = rd_en & valid;
  assign wr    = push & (~full | pop);
  assign valid = count != '0;
  assign data  = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (wr && !rst) mem[wp] <= sh;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      wp      <= wr ? wp + AW'(1) : wp;
      rp      <= pop ? rp + AW'(1) : rp;
      count   <= count + (AW+1)'(wr) - (AW+1)'(pop);
      overrun <= push & full & ~pop;
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed table-driven bench for uart_rx_cfg (no-parity and even-parity instances).
module tb_uart_rx_cfg;
  localparam int CPB = 256;
  logic clk = 1'b0, rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rd0 = 1'b0, rd1 = 1'b0;
  logic [7:0] d0, d1;
  logic [2:0] c0, c1;
  logic v0, v1, fe0, fe1, pe0, pe1, ov0, ov1;
  int n_chk = 0, n_fail = 0;
  int fe0c = 0, pe0c = 0, ov0c = 0, fe1c = 0, pe1c = 0, ov1c = 0, both1c = 0;
  always #5 clk = ~clk;
  uart_rx_cfg #(.CLOCK_HZ(25600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd0), .data(d0), .valid(v0), .count(c0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0));
  uart_rx_cfg #(.CLOCK_HZ(25600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd1), .data(d1), .valid(v1), .count(c1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1));
  always @(negedge clk) begin
    if (fe0) fe0c++;
    if (pe0) pe0c++;
    if (ov0) ov0c++;
    if (fe1) fe1c++;
    if (pe1) pe1c++;
    if (ov1) ov1c++;
    if (fe1 && pe1) both1c++;
  end
  typedef struct {
    int sel;
    logic [7:0] d;
    logic p;
    logic s;
    int push;
    int fe;
    int pe;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic send(input int sel, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 1) rx1 = f[i]; else rx0 = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
  endtask
  task automatic idle(input int sel, input int n);
    @(negedge clk);
    if (sel == 1) rx1 = 1'b1; else rx0 = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic pop(input int sel);
    @(negedge clk);
    if (sel == 1) rd1 = 1'b1; else rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask
  function automatic logic [15:0] fr0(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction
  function automatic logic [15:0] fr1(input logic [7:0] d, input logic p, input logic s);
    return {5'b0, s, p, d, 1'b0};
  endfunction
  initial begin
    int fb, pb, bb, ob;
    tv[0] = '{0, 8'hAA, 1'b0, 1'b1, 1, 0, 0};
    tv[1] = '{0, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    tv[2] = '{0, 8'hFF, 1'b0, 1'b1, 1, 0, 0};
    tv[3] = '{0, 8'h81, 1'b0, 1'b0, 0, 1, 0};
    tv[4] = '{1, 8'h07, 1'b0, 1'b1, 0, 0, 1};
    tv[5] = '{1, 8'h07, 1'b1, 1'b1, 1, 0, 0};
    tv[6] = '{1, 8'h03, 1'b0, 1'b1, 1, 0, 0};
    tv[7] = '{1, 8'h03, 1'b1, 1'b0, 0, 1, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", v0, 0);
    chk("reset_count", c0, 0);
    chk("reset_data", d0, 0);
    chk("reset_count1", c1, 0);
    chk("reset_flags", fe0 | pe0 | ov0 | fe1 | pe1 | ov1, 0);
    pop(0);
    chk("pop_empty_count", c0, 0);
    for (int i = 0; i < 8; i++) begin
      fb = tv[i].sel ? fe1c : fe0c;
      pb = tv[i].sel ? pe1c : pe0c;
      bb = both1c;
      send(tv[i].sel, tv[i].sel ? fr1(tv[i].d, tv[i].p, tv[i].s) : fr0(tv[i].d, tv[i].s), tv[i].sel ? 11 : 10);
      idle(tv[i].sel, CPB);
      chk($sformatf("vec%0d_count", i), tv[i].sel ? c1 : c0, tv[i].push);
      chk($sformatf("vec%0d_valid", i), tv[i].sel ? v1 : v0, tv[i].push);
      chk($sformatf("vec%0d_frame_err", i), (tv[i].sel ? fe1c : fe0c) - fb, tv[i].fe);
      chk($sformatf("vec%0d_parity_err", i), (tv[i].sel ? pe1c : pe0c) - pb, tv[i].pe);
      if (tv[i].fe == 1 && tv[i].pe == 1) chk($sformatf("vec%0d_same_cycle", i), both1c - bb, 1);
      if (tv[i].push == 1) begin
        chk($sformatf("vec%0d_data", i), tv[i].sel ? d1 : d0, tv[i].d);
        pop(tv[i].sel);
      end
    end
    fb = fe0c;
    send(0, fr0(8'h55, 1'b0), 10);
    repeat (3 * CPB) @(negedge clk);
    chk("break_frame_err", fe0c - fb, 1);
    chk("break_no_push", c0, 0);
    idle(0, CPB);
    send(0, fr0(8'h3C, 1'b1), 10);
    idle(0, CPB);
    chk("break_frame_err_once", fe0c - fb, 1);
    chk("break_next_count", c0, 1);
    chk("break_next_data", d0, 8'h3C);
    pop(0);
    ob = ov0c;
    for (int i = 1; i <= 5; i++) send(0, fr0(8'(i), 1'b1), 10);
    idle(0, CPB);
    chk("ovr_count", c0, 4);
    chk("ovr_pulse", ov0c - ob, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_pop%0d", i), d0, i);
      pop(0);
    end
    chk("ovr_drained", c0, 0);
    fb = fe0c;
    pb = pe0c;
    @(negedge clk);
    rx0 = 1'b0;
    repeat (100) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_count", c0, 0);
    chk("glitch_flags", (fe0c - fb) + (pe0c - pb), 0);
    send(0, fr0(8'h96, 1'b1), 10);
    idle(0, CPB);
    chk("glitch_next_data", d0, 8'h96);
    pop(0);
    send(0, fr0(8'hC3, 1'b1), 5);
    @(negedge clk);
    rst = 1'b1;
    rx0 = 1'b1;
    @(negedge clk);
    chk("midrst_valid", v0, 0);
    @(negedge clk);
    rst = 1'b0;
    fb = fe0c;
    repeat (2 * CPB) @(negedge clk);
    chk("midrst_no_push", c0, 0);
    send(0, fr0(8'hAA, 1'b1), 10);
    idle(0, CPB);
    chk("midrst_count", c0, 1);
    chk("midrst_data", d0, 8'hAA);
    chk("midrst_no_flag", fe0c - fb, 0);
    pop(0);
    rst = 1'b1;
    rx0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB - 2) @(negedge clk);
    send(0, {7'b0, 1'b1, 8'h5A}, 9);
    idle(0, CPB);
    chk("low_after_reset_data", d0, 8'h5A);
    chk("low_after_reset_count", c0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
